// File: rtl/irq_source_router_pkg.sv
// Shared definitions for irq_source_router: register map, claim miss code,
// level width and the bus slave state type.
package irq_source_router_pkg;

   localparam int         LVLW      = 3;
   localparam logic [4:0] A_LEVEL   = 5'h00;
   localparam logic [4:0] A_EN_LO   = 5'h10;
   localparam logic [4:0] A_EN_HI   = 5'h11;
   localparam logic [4:0] A_PEND_LO = 5'h12;
   localparam logic [4:0] A_PEND_HI = 5'h13;
   localparam logic [4:0] A_TRIG_LO = 5'h14;
   localparam logic [4:0] A_TRIG_HI = 5'h15;
   localparam logic [4:0] A_CLAIM   = 5'h18;
   localparam logic [7:0] NO_CLAIM  = 8'hFF;

   typedef enum logic {S_IDLE, S_ACK} bus_st_t;

   // Big-endian lanes: sel[3] addresses byte offset 0; sel[0] alone (or none) means offset 3.
   function automatic logic [4:0] byte_addr(input logic [2:0] word, input logic [2:0] sel_hi);
      logic [1:0] lane;
      if (sel_hi[2])      lane = 2'd0;
      else if (sel_hi[1]) lane = 2'd1;
      else if (sel_hi[0]) lane = 2'd2;
      else                lane = 2'd3;
      return {word, lane};
   endfunction

endpackage

// File: rtl/irq_source_router_if.sv
// Wishbone 8-bit slave bundle between the m68kwb bus master and irq_source_router.
interface irq_source_router_if;
   logic       wb_stb_i;
   logic       wb_we_i;
   logic [4:0] wb_adr_i;
   logic [3:0] wb_sel_i;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;

   modport master (output wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                   input  wb_dat_o, wb_ack_o);
   modport slave  (input  wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                   output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/irq_source_router_rr_pick.sv
// Round-robin picker: first set request strictly after start_i, wrapping mod NSRC.
module rr_pick #(
   parameter int NSRC = 8,
   parameter int SRCW = 4
) (
   input  logic [NSRC-1:0] req_i,
   input  logic [SRCW-1:0] start_i,
   output logic            hit_o,
   output logic [SRCW-1:0] idx_o
);

   logic            hit_hi, hit_lo;
   logic [SRCW-1:0] idx_hi, idx_lo;

   // Split into "above the pointer" and "wrapped" halves; the upper half has priority.
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (req_i[i]) begin
            if (i > int'(start_i)) begin
               if (!hit_hi) begin
                  hit_hi = 1'b1;
                  idx_hi = SRCW'(i);
               end
            end else if (!hit_lo) begin
               hit_lo = 1'b1;
               idx_lo = SRCW'(i);
            end
         end
      end
      hit_o = hit_hi | hit_lo;
      idx_o = hit_hi ? idx_hi : idx_lo;
   end

endmodule

// File: rtl/irq_source_router.sv
// Routes NSRC peripheral IRQs onto the 7 CPU interrupt levels with per-level round-robin claim.
// Optional per-source level-triggered mode: define IRQ_ROUTER_LEVEL_TRIG_EN.
module irq_source_router
   import irq_source_router_pkg::*;
#(
   parameter int NSRC = 8,
   parameter int SRCW = 4
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_reset_i,
   irq_source_router_if.slave   wb,
   input  logic [NSRC-1:0]      src_irq_i,
   output logic [6:0]           int_o
);

   logic [NSRC-1:0][LVLW-1:0] level_q;
   logic [NSRC-1:0]           en_q, pend_q, pend_n, src_q;
   logic [NSRC-1:0]           set_v, clr_v;
   logic [6:0][SRCW-1:0]      rr_q;
   logic [6:0][NSRC-1:0]      elig;
   bus_st_t                   st_q;
   logic [7:0]                dat_q, rd_data;
   logic                      ack_q;
   logic [4:0]                baddr;
   logic                      access, wr_acc, claim_acc;
   logic [2:0]                claim_l;
   logic [NSRC-1:0]           pick_req;
   logic [SRCW-1:0]           pick_start, pick_idx;
   logic                      pick_hit;
   logic [15:0]               en16, pend16, dat16, w1c16;
   logic                      unused_bits;
`ifdef IRQ_ROUTER_LEVEL_TRIG_EN
   logic [NSRC-1:0]           trig_q;
   logic [15:0]               trig16;
`endif

   assign baddr       = byte_addr(wb.wb_adr_i[4:2], wb.wb_sel_i[3:1]);
   assign access      = (st_q == S_IDLE) && wb.wb_stb_i;
   assign wr_acc      = access && wb.wb_we_i;
   assign claim_l     = baddr[2:0];
   assign claim_acc   = access && !wb.wb_we_i && (baddr[4:3] == A_CLAIM[4:3]) && (claim_l != 3'd7);
   assign dat16       = {wb.wb_dat_i, wb.wb_dat_i};
   assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_sel_i[0]};

   always_comb begin
      en16   = '0;
      pend16 = '0;
      en16[NSRC-1:0]   = en_q;
      pend16[NSRC-1:0] = pend_q;
`ifdef IRQ_ROUTER_LEVEL_TRIG_EN
      trig16 = '0;
      trig16[NSRC-1:0] = trig_q;
`endif
   end

   always_comb begin
      elig = '0;
      for (int l = 0; l < 7; l++)
         for (int i = 0; i < NSRC; i++)
            elig[l][i] = pend_q[i] & en_q[i] & (level_q[i] == LVLW'(l + 1));
   end

   // One picker serves all levels; only the level being claimed matters each cycle.
   assign pick_req   = (claim_l == 3'd7) ? '0 : elig[claim_l];
   assign pick_start = (claim_l == 3'd7) ? '0 : rr_q[claim_l];

   rr_pick #(.NSRC(NSRC), .SRCW(SRCW)) u_pick (
      .req_i   (pick_req),
      .start_i (pick_start),
      .hit_o   (pick_hit),
      .idx_o   (pick_idx)
   );

   always_comb begin
      w1c16 = '0;
      if (wr_acc && baddr == A_PEND_LO) w1c16[7:0]  = wb.wb_dat_i;
      if (wr_acc && baddr == A_PEND_HI) w1c16[15:8] = wb.wb_dat_i;
      for (int i = 0; i < NSRC; i++) begin
         set_v[i] = src_irq_i[i] & ~src_q[i] & en_q[i] & (level_q[i] != '0);
         clr_v[i] = w1c16[i] | (claim_acc & pick_hit & (pick_idx == SRCW'(i)));
      end
      // An edge arriving with a clear keeps the bit set.
      pend_n = (pend_q & ~clr_v) | set_v;
`ifdef IRQ_ROUTER_LEVEL_TRIG_EN
      for (int i = 0; i < NSRC; i++)
         if (trig_q[i]) pend_n[i] = src_irq_i[i] & en_q[i];
`endif
   end

   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < NSRC; i++)
         if (baddr == A_LEVEL + 5'(i)) rd_data = 8'(level_q[i]);
      case (baddr)
         A_EN_LO:   rd_data = en16[7:0];
         A_EN_HI:   rd_data = en16[15:8];
         A_PEND_LO: rd_data = pend16[7:0];
         A_PEND_HI: rd_data = pend16[15:8];
`ifdef IRQ_ROUTER_LEVEL_TRIG_EN
         A_TRIG_LO: rd_data = trig16[7:0];
         A_TRIG_HI: rd_data = trig16[15:8];
`else
         A_TRIG_LO, A_TRIG_HI: rd_data = 8'h00;
`endif
         default: ;
      endcase
      if (baddr[4:3] == A_CLAIM[4:3] && claim_l != 3'd7)
         rd_data = pick_hit ? 8'(pick_idx) : NO_CLAIM;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_reset_i) begin
         level_q <= '0;
         en_q    <= '0;
         pend_q  <= '0;
         src_q   <= '0;
         int_o   <= '0;
         for (int l = 0; l < 7; l++) rr_q[l] <= SRCW'(NSRC - 1);
`ifdef IRQ_ROUTER_LEVEL_TRIG_EN
         trig_q  <= '0;
`endif
      end else begin
         src_q  <= src_irq_i;
         pend_q <= pend_n;
         for (int l = 0; l < 7; l++) int_o[l] <= |elig[l];
         for (int i = 0; i < NSRC; i++) begin
            if (wr_acc && baddr == A_LEVEL + 5'(i)) level_q[i] <= wb.wb_dat_i[LVLW-1:0];
            if (wr_acc && baddr == ((i < 8) ? A_EN_LO : A_EN_HI)) en_q[i] <= dat16[i];
`ifdef IRQ_ROUTER_LEVEL_TRIG_EN
            if (wr_acc && baddr == ((i < 8) ? A_TRIG_LO : A_TRIG_HI)) trig_q[i] <= dat16[i];
`endif
         end
         if (claim_acc && pick_hit) rr_q[claim_l] <= pick_idx;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_reset_i) begin
         st_q  <= S_IDLE;
         ack_q <= 1'b0;
         dat_q <= 8'h00;
      end else begin
         case (st_q)
            S_IDLE: if (wb.wb_stb_i) begin
               dat_q <= rd_data;
               ack_q <= 1'b1;
               st_q  <= S_ACK;
            end
            S_ACK: begin
               ack_q <= 1'b0;
               st_q  <= S_IDLE;
            end
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign wb.wb_dat_o = dat_q;
   assign wb.wb_ack_o = ack_q;

endmodule

// File: tb/tb_irq_source_router.sv
// Scoreboard bench for irq_source_router: a cycle-level reference model predicts read
// data, int_o and ack; a negedge monitor pops expected read data on every ack.
module tb_irq_source_router;

   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NSRC-1:0] src = '0;
   logic [6:0]      int_o;

   irq_source_router_if bus_if();

   irq_source_router #(.NSRC(NSRC), .SRCW(4)) dut (
      .wb_clk_i   (clk),
      .wb_reset_i (rst),
      .wb         (bus_if),
      .src_irq_i  (src),
      .int_o      (int_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rd;
      logic [7:0] d;
      string      tag;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   int  m_lvl [NSRC];
   bit  m_en  [NSRC];
   bit  m_pend[NSRC];
   bit  m_prev[NSRC];
   int  m_rr  [8];
   bit  m_busy;

   // current bus request as the bench sees it
   bit         d_stb, d_we, d_usec;
   int         d_ba;
   logic [7:0] d_dat, d_cexp;
   string      d_tag;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < NSRC; i++) begin
         m_lvl[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
      end
      for (int l = 0; l < 8; l++) m_rr[l] = NSRC - 1;
      m_busy = 0;
   endfunction

   function automatic logic [7:0] m_read(input int ba);
      logic [7:0] r = 8'h00;
      if (ba < NSRC) return 8'(m_lvl[ba]);
      if (ba >= 'h10 && ba <= 'h13) begin
         for (int b = 0; b < 8; b++) begin
            int i = b + ((ba & 1) != 0 ? 8 : 0);
            if (i < NSRC) r[b] = (ba < 'h12) ? m_en[i] : m_pend[i];
         end
         return r;
      end
      if (ba >= 'h18 && ba <= 'h1E) begin
         int lv = ba - 'h17;
         for (int k = 1; k <= NSRC; k++) begin
            int i = (m_rr[lv] + k) % NSRC;
            if (m_pend[i] && m_en[i] && m_lvl[i] == lv) begin
               m_pend[i] = 0;
               m_rr[lv]  = i;
               return 8'(i);
            end
         end
         return 8'hFF;
      end
      return 8'h00;
   endfunction

   function automatic void m_write(input int ba, input logic [7:0] d);
      if (ba < NSRC) m_lvl[ba] = int'(d[2:0]);
      for (int b = 0; b < 8; b++) begin
         int i = b + ((ba & 1) != 0 ? 8 : 0);
         if (i < NSRC && (ba == 'h10 || ba == 'h11)) m_en[i] = d[b];
         if (i < NSRC && (ba == 'h12 || ba == 'h13) && d[b]) m_pend[i] = 0;
      end
   endfunction

   // Advance one clock: predict from pre-edge state, then check int_o and ack after the edge.
   task automatic tick();
      bit       set_b[NSRC];
      bit [6:0] ei = '0;
      exp_t     e;
      if (rst) begin
         m_reset();
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (m_pend[i] && m_en[i] && m_lvl[i] >= 1) ei[m_lvl[i]-1] = 1'b1;
            set_b[i] = src[i] && !m_prev[i] && m_en[i] && m_lvl[i] != 0;
         end
         if (!m_busy && d_stb) begin
            e.rd  = !d_we;
            e.d   = 8'h00;
            e.tag = d_tag;
            if (d_we) m_write(d_ba, d_dat);
            else      e.d = m_read(d_ba);
            if (d_usec) e.d = d_cexp;
            sbq.push_back(e);
            m_busy = 1;
         end else begin
            m_busy = 0;
         end
         for (int i = 0; i < NSRC; i++) begin
            if (set_b[i]) m_pend[i] = 1;
            m_prev[i] = src[i];
         end
      end
      @(posedge clk);
      #1;
      check("int_o", 32'(int_o), 32'(ei));
      check("ack", 32'(bus_if.wb_ack_o), 32'(m_busy));
   endtask

   task automatic drive(input bit stb, input bit we, input int ba, input logic [7:0] d);
      logic [4:0] a;
      logic [3:0] s;
      a[4:2] = 3'(ba >> 2);
      a[1:0] = 2'($urandom);
      case (ba & 3)
         0: s = {1'b1, 3'($urandom)};
         1: s = {2'b01, 2'($urandom)};
         2: s = {3'b001, 1'($urandom)};
         default: s = {3'b000, 1'($urandom)};
      endcase
      bus_if.wb_stb_i = stb;
      bus_if.wb_we_i  = we;
      bus_if.wb_adr_i = a;
      bus_if.wb_sel_i = s;
      bus_if.wb_dat_i = d;
      d_stb = stb; d_we = we; d_ba = ba; d_dat = d;
   endtask

   task automatic bus(input bit we, input int ba, input logic [7:0] d = 8'h00,
                      input bit usec = 0, input logic [7:0] cexp = 8'h00, input string tag = "rd");
      d_usec = usec; d_cexp = cexp; d_tag = tag;
      drive(1'b1, we, ba, d);
      tick();
      drive(1'b0, 1'b0, 0, 8'h00);
      tick();
   endtask

   // monitor: every ack must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_if.wb_ack_o === 1'b1) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_ack: ack seen with no outstanding access at %0t", $time);
            end else begin
               e = sbq.pop_front();
               if (e.rd) check({"rd_", e.tag}, 32'(bus_if.wb_dat_o), 32'(e.d));
            end
         end
      end
   end

   initial begin
      d_usec = 0; d_cexp = '0; d_tag = "";
      m_reset();
      drive(1'b0, 1'b0, 0, 8'h00);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      for (int ba = 0; ba <= 'h13; ba++) bus(0, ba, 0, 1, 8'h00, "reset");

      // level 5 source 2: two-cycle latency, claim clears
      bus(1, 'h02, 8'h05);
      bus(1, 'h10, 8'h04);
      src[2] = 1'b1;
      tick();
      tick();
      check("int_latency", 32'(int_o), 32'h10);
      src[2] = 1'b0;
      bus(0, 'h1C, 0, 1, 8'h02, "claim_l5");
      check("int_after_claim", 32'(int_o), 32'h00);

      // round robin on level 3
      bus(1, 'h01, 8'h03);
      bus(1, 'h03, 8'h03);
      bus(1, 'h06, 8'h03);
      bus(1, 'h10, 8'h4E);
      src = 8'h4A; tick(); src = 8'h00; tick();
      bus(0, 'h1A, 0, 1, 8'h01, "rr_a");
      bus(0, 'h1A, 0, 1, 8'h03, "rr_b");
      bus(0, 'h1A, 0, 1, 8'h06, "rr_c");
      bus(0, 'h1A, 0, 1, 8'hFF, "rr_empty");
      src = 8'h4A; tick(); src = 8'h00; tick();
      bus(0, 'h1A, 0, 1, 8'h01, "rr_wrap");

      // edge on source 4 during its own claim
      bus(1, 'h04, 8'h02);
      bus(1, 'h10, 8'h5E);
      src[4] = 1'b1; tick(); src[4] = 1'b0; tick();
      src[4] = 1'b1;
      bus(0, 'h19, 0, 1, 8'h04, "claim_edge");
      bus(0, 'h12, 0, 1, 8'h58, "pend_edge_wins");
      src[4] = 1'b0;

      // disabled source, W1C, unmapped space
      bus(1, 'h00, 8'h07);
      src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
      bus(0, 'h12, 0, 1, 8'h58, "pend_disabled");
      bus(1, 'h12, 8'hFF);
      bus(0, 'h12, 0, 1, 8'h00, "w1c_all");
      bus(0, 'h1A, 0, 1, 8'hFF, "claim_empty3");
      bus(0, 'h19, 0, 1, 8'hFF, "claim_empty2");
      bus(1, 'h11, 8'hFF);
      bus(0, 'h11, 0, 1, 8'h00, "en_hi_absent");
      bus(0, 'h08, 0, 1, 8'h00, "level8_absent");
      bus(0, 'h14, 0, 1, 8'h00, "trig_unmapped");
      bus(0, 'h1F, 0, 1, 8'h00, "claim8_unmapped");

      // level change while pending moves the request
      src[3] = 1'b1; tick(); src[3] = 1'b0; tick(); tick();
      bus(1, 'h03, 8'h06);
      tick(); tick();
      check("int_moved", 32'(int_o), 32'h20);

      // reset during a strobe: no ack for the aborted access
      drive(1'b1, 1'b0, 'h10, 8'h00);
      rst = 1'b1;
      tick();
      drive(1'b0, 1'b0, 0, 8'h00);
      rst = 1'b0;
      tick();
      bus(0, 'h10, 0, 1, 8'h00, "en_after_rst");

      // randomized traffic
      bus(1, 'h10, 8'($urandom) | 8'h0F);
      for (int n = 0; n < 700; n++) begin
         int r = $urandom_range(0, 9);
         case (r)
            0, 1: begin src = NSRC'($urandom); tick(); end
            2: bus(1, $urandom_range(0, 'h1F), 8'($urandom));
            3, 4, 5: bus(0, 'h18 + $urandom_range(0, 6), 0, 0, 0, "rnd_claim");
            6: bus(0, $urandom_range(0, 'h1F), 0, 0, 0, "rnd_read");
            7: bus(1, 'h12, 8'($urandom) & 8'($urandom));
            8: tick();
            default: begin
               src = NSRC'($urandom);
               bus(0, 'h18 + $urandom_range(0, 6), 0, 0, 0, "rnd_edge_claim");
            end
         endcase
      end

      tick(); tick(); tick();
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
